// File: rtl/proc_pkg.sv
// Shared definitions for the 9-bit processor control path: word width, opcodes
// and the control FSM state encoding.
package proc_pkg;

    localparam int unsigned DW = 9;

    localparam logic [2:0] OP_MV  = 3'b000;
    localparam logic [2:0] OP_MVI = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

endpackage

// File: rtl/proc_control_fsm_dec3to8.sv
// 3-bit to one-hot 8-bit decoder; the output is all zero when the enable is low.
module dec3to8 (
    input  logic       en,
    input  logic [2:0] sel,
    output logic [7:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/proc_control_fsm.sv
// Control unit for the 9-bit processor: captures an instruction into IR and
// sequences bus-source selects and load enables over 2-4 cycles.
module proc_control_fsm
    import proc_pkg::*;
#(
    parameter int unsigned NREG = 8,
    parameter int unsigned DW   = proc_pkg::DW
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            run,
    input  logic [DW-1:0]   din,
    output logic            ir_in,
    output logic [NREG-1:0] r_in,
    output logic [NREG-1:0] rsele,
    output logic            gsele,
    output logic            dsele,
    output logic            a_in,
    output logic            g_in,
    output logic            addsub,
    output logic            busy,
    output logic            done
);

    state_t        state_q, state_d;
    logic [DW-1:0] ir_q, ir_d;

    logic [2:0] op;
    logic       rin_x_en;
    logic       rsel_x_en;
    logic       rsel_y_en;
    logic [7:0] x_onehot;
    logic [7:0] y_onehot;

    assign op = ir_q[8:6];

    dec3to8 u_dec_x (
        .en     (rin_x_en | rsel_x_en),
        .sel    (ir_q[5:3]),
        .onehot (x_onehot)
    );

    dec3to8 u_dec_y (
        .en     (rsel_y_en),
        .sel    (ir_q[2:0]),
        .onehot (y_onehot)
    );

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        ir_in     = 1'b0;
        rin_x_en  = 1'b0;
        rsel_x_en = 1'b0;
        rsel_y_en = 1'b0;
        gsele     = 1'b0;
        dsele     = 1'b0;
        a_in      = 1'b0;
        g_in      = 1'b0;
        addsub    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            T0: begin
                ir_in = run;
                if (run) begin
                    ir_d    = din;
                    state_d = T1;
                end
            end
            T1: begin
                busy = 1'b1;
                case (op)
                    OP_MV: begin
                        rsel_y_en = 1'b1;
                        rin_x_en  = 1'b1;
                        done      = 1'b1;
                        state_d   = T0;
                    end
                    OP_MVI: begin
                        dsele    = 1'b1;
                        rin_x_en = 1'b1;
                        done     = 1'b1;
                        state_d  = T0;
                    end
                    OP_ADD, OP_SUB: begin
                        rsel_x_en = 1'b1;
                        a_in      = 1'b1;
                        state_d   = T2;
                    end
                    default: begin
                        done    = 1'b1;
                        state_d = T0;
                    end
                endcase
            end
            T2: begin
                busy      = 1'b1;
                rsel_y_en = 1'b1;
                g_in      = 1'b1;
                addsub    = op[0];
                state_d   = T3;
            end
            T3: begin
                busy     = 1'b1;
                gsele    = 1'b1;
                rin_x_en = 1'b1;
                done     = 1'b1;
                state_d  = T0;
            end
            default: state_d = T0;
        endcase

        // Reset masks every strobe so an aborted instruction writes nothing.
        if (reset) begin
            ir_in     = 1'b0;
            rin_x_en  = 1'b0;
            rsel_x_en = 1'b0;
            rsel_y_en = 1'b0;
            gsele     = 1'b0;
            dsele     = 1'b0;
            a_in      = 1'b0;
            g_in      = 1'b0;
            addsub    = 1'b0;
            busy      = 1'b0;
            done      = 1'b0;
        end
    end

    assign r_in  = rin_x_en ? x_onehot : '0;
    assign rsele = (rsel_x_en ? x_onehot : '0) | y_onehot;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= T0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
        end
    end

endmodule

// File: tb/tb_proc_control_fsm.sv
// Self-checking bench for proc_control_fsm: directed scenarios plus randomized
// instruction streams compared against a cycle-indexed instruction model.
module tb_proc_control_fsm;

    typedef struct packed {
        logic       ir_in;
        logic [7:0] r_in;
        logic [7:0] rsele;
        logic       gsele;
        logic       dsele;
        logic       a_in;
        logic       g_in;
        logic       addsub;
        logic       busy;
        logic       done;
    } outs_t;

    logic       clock;
    logic       reset;
    logic       run;
    logic [8:0] din;
    logic       ir_in;
    logic [7:0] r_in;
    logic [7:0] rsele;
    logic       gsele;
    logic       dsele;
    logic       a_in;
    logic       g_in;
    logic       addsub;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;
    bit inv_en   = 1'b0;

    proc_control_fsm #(.NREG(8), .DW(9)) dut (
        .clock  (clock),
        .reset  (reset),
        .run    (run),
        .din    (din),
        .ir_in  (ir_in),
        .r_in   (r_in),
        .rsele  (rsele),
        .gsele  (gsele),
        .dsele  (dsele),
        .a_in   (a_in),
        .g_in   (g_in),
        .addsub (addsub),
        .busy   (busy),
        .done   (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic outs_t observed();
        outs_t o;
        o = '{ir_in, r_in, rsele, gsele, dsele, a_in, g_in, addsub, busy, done};
        return o;
    endfunction

    // Instruction length in cycles, fetch included.
    function automatic int inst_len(input logic [8:0] ir);
        int op;
        op = int'(ir[8:6]);
        return (op == 2 || op == 3) ? 4 : 2;
    endfunction

    // Expected outputs for cycle k of an instruction (k = 0 is the fetch cycle).
    function automatic outs_t model(input logic [8:0] ir, input int k, input logic run_i);
        outs_t e;
        int op, x, y;
        e  = '0;
        op = int'(ir[8:6]);
        x  = int'(ir[5:3]);
        y  = int'(ir[2:0]);
        if (k == 0) begin
            e.ir_in = run_i;
            return e;
        end
        e.busy = 1'b1;
        if (op >= 4) begin
            e.done = 1'b1;
        end else if (op == 0) begin
            e.rsele = 8'(1 << y);
            e.r_in  = 8'(1 << x);
            e.done  = 1'b1;
        end else if (op == 1) begin
            e.dsele = 1'b1;
            e.r_in  = 8'(1 << x);
            e.done  = 1'b1;
        end else if (k == 1) begin
            e.rsele = 8'(1 << x);
            e.a_in  = 1'b1;
        end else if (k == 2) begin
            e.rsele  = 8'(1 << y);
            e.g_in   = 1'b1;
            e.addsub = (op == 3);
        end else begin
            e.gsele = 1'b1;
            e.r_in  = 8'(1 << x);
            e.done  = 1'b1;
        end
        return e;
    endfunction

    always @(negedge clock) begin
        if (inv_en) begin
            n_checks++;
            if (($countones(rsele) + int'(gsele) + int'(dsele)) > 1 || $countones(r_in) > 1) begin
                n_fail++;
                $display("FAIL invariant t=%0t rsele=%h gsele=%b dsele=%b r_in=%h (need <=1 bus source, r_in one-hot or 0)",
                         $time, rsele, gsele, dsele, r_in);
            end
        end
    end

    task automatic test_reset();
        outs_t act, exp;
        reset = 1'b1;
        run   = 1'b1;
        din   = 9'h1FF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            act = observed();
            n_checks++;
            if (act !== outs_t'(0)) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d got=%h want=%h", i, act, outs_t'(0));
            end
            @(posedge clock); #1;
        end
        reset = 1'b0;
        inv_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            act = observed();
            exp = model(9'h1FF, k, run);
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL reset_release k=%0d got=%h want=%h", k, act, exp);
            end
            @(posedge clock); #1;
            run = 1'b0;
        end
    endtask

    task automatic test_directed(input logic [8:0] ir, input logic [8:0] imm, input string name);
        outs_t act, exp;
        int len;
        len = inst_len(ir);
        for (int k = 0; k < len; k++) begin
            run = (k == 0) ? 1'b1 : 1'(k % 2);
            din = (k == 0) ? ir : imm;
            @(negedge clock);
            act = observed();
            exp = model(ir, k, run);
            n_checks++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s k=%0d got=%h want=%h", name, k, act, exp);
            end
            if (dsele) begin
                n_checks++;
                if (din !== imm) begin
                    n_fail++;
                    $display("FAIL %s_bus got=%h want=%h", name, din, imm);
                end
            end
            @(posedge clock); #1;
        end
        run = 1'b0;
        @(negedge clock);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle busy got=%b want=0", name, busy);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        logic [8:0] prog [2];
        outs_t act, exp;
        prog[0] = 9'b010_001_001;
        prog[1] = 9'b000_111_001;
        run = 1'b1;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < inst_len(prog[p]); k++) begin
                din = (k == 0) ? prog[p] : 9'(($urandom));
                @(negedge clock);
                act = observed();
                exp = model(prog[p], k, 1'b1);
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL back_to_back inst%0d k=%0d got=%h want=%h", p, k, act, exp);
                end
                @(posedge clock); #1;
            end
        end
        run = 1'b0;
        @(negedge clock);
        n_checks++;
        if (observed() !== outs_t'(0)) begin
            n_fail++;
            $display("FAIL back_to_back_idle got=%h want=%h", observed(), outs_t'(0));
        end
        @(posedge clock); #1;
    endtask

    task automatic test_abort();
        logic [8:0] ir;
        int rin_seen;
        ir = 9'b010_100_011;
        rin_seen = 0;
        for (int k = 0; k < 4; k++) begin
            run   = (k == 0);
            reset = (k == 2);
            din   = (k == 0) ? ir : 9'h155;
            @(negedge clock);
            if (r_in !== 8'h00) rin_seen++;
            if (k == 2) begin
                n_checks++;
                if (observed() !== outs_t'(0)) begin
                    n_fail++;
                    $display("FAIL abort_reset_cycle got=%h want=%h", observed(), outs_t'(0));
                end
            end
            if (k == 3) begin
                n_checks++;
                if (observed() !== outs_t'(0)) begin
                    n_fail++;
                    $display("FAIL abort_t0 got=%h want=%h", observed(), outs_t'(0));
                end
            end
            @(posedge clock); #1;
        end
        reset = 1'b0;
        n_checks++;
        if (rin_seen != 0) begin
            n_fail++;
            $display("FAIL abort_no_write r_in cycles got=%0d want=0", rin_seen);
        end
    endtask

    task automatic test_random(input int n_inst);
        outs_t act, exp;
        logic [8:0] ir;
        int gap;
        for (int n = 0; n < n_inst; n++) begin
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                run = 1'b0;
                din = 9'($urandom);
                @(negedge clock);
                n_checks++;
                if (observed() !== outs_t'(0)) begin
                    n_fail++;
                    $display("FAIL random_idle n=%0d got=%h want=%h", n, observed(), outs_t'(0));
                end
                @(posedge clock); #1;
            end
            ir = 9'($urandom);
            for (int k = 0; k < inst_len(ir); k++) begin
                run = (k == 0) ? 1'b1 : 1'($urandom);
                din = (k == 0) ? ir : 9'($urandom);
                @(negedge clock);
                act = observed();
                exp = model(ir, k, run);
                n_checks++;
                if (act !== exp) begin
                    n_fail++;
                    $display("FAIL random n=%0d ir=%h k=%0d got=%h want=%h", n, ir, k, act, exp);
                end
                @(posedge clock); #1;
            end
        end
        run = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        run   = 1'b0;
        din   = '0;
        test_reset();
        test_directed(9'b000_101_010, 9'h000, "mv_r5_r2");
        test_directed(9'b001_000_000, 9'h1AB, "mvi_r0");
        test_directed(9'b011_011_110, 9'h0F0, "sub_r3_r6");
        test_directed(9'b010_010_010, 9'h033, "add_same_reg");
        test_back_to_back();
        test_abort();
        test_directed(9'b110_010_101, 9'h0AA, "undef_110");
        test_random(60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/proc_control_fsm.md
Name: proc_control_fsm

Overview:
Control unit for the 9-bit processor. It captures each instruction word from DIN into an internal IR and sequences it over 2–4 clock cycles. Each cycle it drives the bus-source selects (rsele/gsele/dsele) consumed by muxsmthng2one, plus the register, accumulator and G load enables. It sits directly upstream of the bus mux and the register file/ALU.

Parameters:
- NREG, 8, number of general registers; equals the width of rsele and r_in, fixed by the 3-bit register field.
- DW, 9, instruction/data word width.

Ports:
- clock, input, 1, system clock; all state updates on rising edge.
- reset, input, 1, synchronous, active-high; forces FSM to T0 and IR to 0.
- run, input, 1, start request; sampled only in T0.
- din, input, DW, instruction word in T0; immediate operand in T1 of mvi (routed by the mux, not read here).
- ir_in, output, 1, IR load strobe (mirror of the internal IR capture).
- r_in, output, NREG, one-hot register write enable.
- rsele, output, NREG, one-hot register bus-source select.
- gsele, output, 1, select G onto bus.
- dsele, output, 1, select din onto bus.
- a_in, output, 1, load accumulator A from bus.
- g_in, output, 1, load G from ALU result.
- addsub, output, 1, ALU op: 0 = add, 1 = sub; valid when g_in = 1.
- busy, output, 1, high in T1..T3.
- done, output, 1, one-cycle pulse in the last cycle of an instruction.

Behaviour:
- Instruction format is IIIXXXYYY: op = ir[8:6], X = ir[5:3], Y = ir[2:0].
- States: T0 (idle/fetch), T1, T2, T3, encoded 2-bit.
- All outputs are combinational from (state, ir, run) and are all 0 while reset = 1.
- After reset: state T0, ir = 0, every output 0 until run is seen.
- T0:
  - ir_in = run.
  - If run = 1: ir <= din, next state T1.
  - Else stay in T0 with all outputs 0.
- op 000, mv Rx,Ry:
  - T1: rsele[Y] = 1, r_in[X] = 1, done = 1; next T0.
  - Latency is 2 cycles including fetch.
- op 001, mvi Rx,#D:
  - T1: dsele = 1, r_in[X] = 1, done = 1; next T0.
  - The immediate must be on din during T1.
- op 010, add Rx,Ry; op 011, sub Rx,Ry:
  - T1: rsele[X] = 1, a_in = 1.
  - T2: rsele[Y] = 1, g_in = 1, addsub = op[0].
  - T3: gsele = 1, r_in[X] = 1, done = 1; next T0.
  - X = Y is legal; result is Rx+Rx or 0.
- op 1xx (undefined):
  - T1: done = 1, no enables or selects; next T0. Architecturally a 2-cycle no-op.
- Invariant: in every cycle at most one of {any rsele bit, gsele, dsele} is 1, and r_in is zero or one-hot.
- run is ignored outside T0; a run held high starts the next instruction in the T0 immediately after done.
- busy = (state != T0).
- Reset asserted mid-instruction aborts it: no partial writes on the reset cycle, state T0 on the next edge.
- An unreachable state encoding (none with 2 bits) is not applicable. The default case returns to T0.

Decomposition:
- Shared package proc_pkg holds:
  - opcode constants OP_MV = 3'b000, OP_MVI = 3'b001, OP_ADD = 3'b010, OP_SUB = 3'b011;
  - state encodings T0..T3;
  - DW = 9.
- One sub-module, dec3to8: 3-bit to one-hot 8-bit decoder with an enable input. It is instantiated twice, once for the X field (r_in, rsele in T1/T3) and once for the Y field (rsele in T2).

Test Plan:
- Reset: hold reset 3 cycles with run = 1 and din = 9'h1FF -> all outputs 0, busy = 0; first cycle after release in T0 gives ir_in = 1.
- mv R5,R2 (din = 9'b000_101_010, run pulse) -> T1: rsele = 8'h04, r_in = 8'h20, done = 1; next cycle busy = 0.
- mvi R0,#0x1AB: T0 din = 9'b001_000_000, T1 din = 9'h1AB -> T1: dsele = 1, r_in = 8'h01, done = 1; through the mux the bus equals 9'h1AB.
- sub R3,R6 (9'b011_011_110) -> T1: rsele = 8'h08, a_in = 1; T2: rsele = 8'h40, g_in = 1, addsub = 1; T3: gsele = 1, r_in = 8'h08, done = 1.
- Back-to-back: run held high across add R1,R1 then mv R7,R1 -> second ir_in = 1 in the cycle right after the first done; total 4 + 2 cycles with no idle gap. Assert the one-hot/exclusive-select invariant every cycle.
- Abort and undefined opcode:
  - Assert reset during T2 of add -> no r_in ever asserts, FSM in T0 next cycle.
  - Then opcode 3'b110 -> T1: done = 1, all enables and selects 0.
